// File: rtl/ea_peripherie.sv
// ----------------------------------------------------------------------------
// ea_peripherie
// Memory-mapped I/O responder for the upper half of the CPU data address space
// (Adresse[31]=1). Speaks the same level-request / done-pulse handshake as the
// data RAM and data cache, so the top level can simply steer done/read-data
// from here whenever Adresse[31] is set.
//
// Registers (Adresse[2:0]):
//   0 LED       RW, LEDBREITE bits, zero-extended on read
//   1 Zaehler   RW, free-running cycle counter (a write loads it, no increment)
//   2 Vergleich RW, compare value for Zaehler
//   3 Status    bit0 Treffer (sticky, write-1-to-clear), bit1 Freigabe (RW)
//   4..7        read 0, writes ignored but acknowledged
//
// Ports:
//   Clock, Reset            system clock, asynchronous active-low reset
//   LesenAn, SchreibenAn    read / write request levels, held until done
//   Adresse, DatenRein      word address and write data
//   DatenRaus               read data, valid while DatenBereit is high
//   DatenBereit             one-cycle read-done pulse
//   DatenGeschrieben        one-cycle write-done pulse
//   Led                     LED register contents
//   Unterbrechung           Treffer AND Freigabe
// ----------------------------------------------------------------------------
module ea_peripherie #(
  parameter int LATENZ    = 1,
  parameter int LEDBREITE = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 LesenAn,
  input  logic                 SchreibenAn,
  input  logic [31:0]          Adresse,
  input  logic [31:0]          DatenRein,
  output logic [31:0]          DatenRaus,
  output logic                 DatenBereit,
  output logic                 DatenGeschrieben,
  output logic [LEDBREITE-1:0] Led,
  output logic                 Unterbrechung
);

  localparam logic [1:0] LEERLAUF = 2'd0;
  localparam logic [1:0] WARTEN   = 2'd1;
  localparam logic [1:0] FERTIG   = 2'd2;
  localparam logic [1:0] SPERRE   = 2'd3;

  logic [1:0]           state_r;
  logic [1:0]           stateNext_s;
  logic [3:0]           warte_r;
  logic [3:0]           warteNext_s;
  logic [2:0]           addr_r;
  logic [31:0]          wdata_r;
  logic                 isWrite_r;
  logic                 latch_s;
  logic                 commit_s;

  logic [LEDBREITE-1:0] led_r;
  logic [31:0]          zaehler_r;
  logic [31:0]          vergleich_r;
  logic                 treffer_r;
  logic                 freigabe_r;
  logic                 unterbrechung_r;
  logic [31:0]          datenRaus_r;
  logic                 datenBereit_r;
  logic                 datenGeschrieben_r;

  logic                 reqActive_s;
  logic [2:0]           selAddr_s;
  logic [31:0]          selData_s;
  logic                 selWrite_s;
  logic                 wrEn_s;
  logic                 rdEn_s;
  logic [31:0]          ledExt_s;
  logic [31:0]          readMux_s;
  logic [31:0]          zaehlerNext_s;
  logic                 trefferNext_s;
  logic                 freigabeNext_s;
  logic                 unusedBits_s;

  // Only the block select and the register index are decoded.
  assign unusedBits_s = &{1'b0, Adresse[30:3]};

  assign reqActive_s = (LesenAn | SchreibenAn) & Adresse[31];

  // Handshake state machine: decides next state, wait count and commit edge.
  always_comb begin
    stateNext_s = state_r;
    warteNext_s = warte_r;
    latch_s     = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      LEERLAUF: begin
        if (reqActive_s) begin
          latch_s = 1'b1;
          if (LATENZ == 32'sd0) begin
            stateNext_s = FERTIG;
            commit_s    = 1'b1;
          end else begin
            stateNext_s = WARTEN;
            warteNext_s = 4'(LATENZ);
          end
        end else begin
          stateNext_s = LEERLAUF;
        end
      end
      WARTEN: begin
        // A dropped request aborts even on the last wait cycle.
        if (!reqActive_s) begin
          stateNext_s = LEERLAUF;
        end else if (warte_r == 4'd1) begin
          stateNext_s = FERTIG;
          commit_s    = 1'b1;
        end else begin
          warteNext_s = warte_r - 4'd1;
        end
      end
      FERTIG: begin
        stateNext_s = SPERRE;
      end
      SPERRE: begin
        // Hold off until the initiator lets go, so a held request is served once.
        if (!LesenAn && !SchreibenAn) begin
          stateNext_s = LEERLAUF;
        end else begin
          stateNext_s = SPERRE;
        end
      end
      default: begin
        stateNext_s = LEERLAUF;
      end
    endcase
  end

  // With zero latency the commit happens on the accept edge, so use live inputs.
  always_comb begin
    if (state_r == LEERLAUF) begin
      selAddr_s  = Adresse[2:0];
      selData_s  = DatenRein;
      selWrite_s = SchreibenAn;
    end else begin
      selAddr_s  = addr_r;
      selData_s  = wdata_r;
      selWrite_s = isWrite_r;
    end
  end

  assign wrEn_s = commit_s & selWrite_s;
  assign rdEn_s = commit_s & ~selWrite_s;

  // Zero-extend the LED register to the bus width.
  always_comb begin
    ledExt_s                  = 32'd0;
    ledExt_s[LEDBREITE-1:0]   = led_r;
  end

  // Read data selection by register index.
  always_comb begin
    case (selAddr_s)
      3'd0:    readMux_s = ledExt_s;
      3'd1:    readMux_s = zaehler_r;
      3'd2:    readMux_s = vergleich_r;
      3'd3:    readMux_s = {30'd0, freigabe_r, treffer_r};
      default: readMux_s = 32'd0;
    endcase
  end

  // Next values of counter and status; a match set beats a same-edge clear.
  always_comb begin
    if (wrEn_s && (selAddr_s == 3'd1)) begin
      zaehlerNext_s = selData_s;
    end else begin
      zaehlerNext_s = zaehler_r + 32'd1;
    end
    if (zaehler_r == vergleich_r) begin
      trefferNext_s = 1'b1;
    end else if (wrEn_s && (selAddr_s == 3'd3) && selData_s[0]) begin
      trefferNext_s = 1'b0;
    end else begin
      trefferNext_s = treffer_r;
    end
    if (wrEn_s && (selAddr_s == 3'd3)) begin
      freigabeNext_s = selData_s[1];
    end else begin
      freigabeNext_s = freigabe_r;
    end
  end

  // Handshake state, wait counter and latched request fields.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r   <= LEERLAUF;
      warte_r   <= 4'd0;
      addr_r    <= 3'd0;
      wdata_r   <= 32'd0;
      isWrite_r <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      warte_r <= warteNext_s;
      if (latch_s) begin
        addr_r    <= Adresse[2:0];
        wdata_r   <= DatenRein;
        isWrite_r <= SchreibenAn;
      end else begin
        addr_r    <= addr_r;
        wdata_r   <= wdata_r;
        isWrite_r <= isWrite_r;
      end
    end
  end

  // Peripheral registers; the interrupt is registered from the next-state values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      led_r           <= '0;
      zaehler_r       <= 32'd0;
      vergleich_r     <= 32'hFFFF_FFFF;
      treffer_r       <= 1'b0;
      freigabe_r      <= 1'b0;
      unterbrechung_r <= 1'b0;
    end else begin
      zaehler_r       <= zaehlerNext_s;
      treffer_r       <= trefferNext_s;
      freigabe_r      <= freigabeNext_s;
      unterbrechung_r <= trefferNext_s & freigabeNext_s;
      if (wrEn_s && (selAddr_s == 3'd0)) begin
        led_r <= selData_s[LEDBREITE-1:0];
      end else begin
        led_r <= led_r;
      end
      if (wrEn_s && (selAddr_s == 3'd2)) begin
        vergleich_r <= selData_s;
      end else begin
        vergleich_r <= vergleich_r;
      end
    end
  end

  // Done pulses and read data; read data holds its value outside the done cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      datenRaus_r        <= 32'd0;
      datenBereit_r      <= 1'b0;
      datenGeschrieben_r <= 1'b0;
    end else begin
      datenBereit_r      <= rdEn_s;
      datenGeschrieben_r <= wrEn_s;
      if (rdEn_s) begin
        datenRaus_r <= readMux_s;
      end else begin
        datenRaus_r <= datenRaus_r;
      end
    end
  end

  assign DatenRaus        = datenRaus_r;
  assign DatenBereit      = datenBereit_r;
  assign DatenGeschrieben = datenGeschrieben_r;
  assign Led              = led_r;
  assign Unterbrechung    = unterbrechung_r;

endmodule

// File: doc/ea_peripherie.md
Name: ea_peripherie

Overview:
- Memory-mapped I/O responder for the CPU data port, serving the upper address half (Adresse[31]=1).
- Answers the same level-request / done-pulse handshake the data RAM and data cache use towards the CPU.
- Holds the LED output register, a free-running cycle counter, a compare register and a sticky match/interrupt status.
- Sits beside the data cache; the top-level steers the CPU's done/read-data from this block when Adresse[31]=1.

Parameters:
- LATENZ, 1, wait states between request acceptance and done pulse (0..15).
- LEDBREITE, 8, width of the LED register (1..32).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- LesenAn  in  1  read request, held by the initiator until DatenBereit.
- SchreibenAn  in  1  write request, held by the initiator until DatenGeschrieben.
- Adresse  in  32  word address; bit31 selects this block, bits[2:0] select the register.
- DatenRein  in  32  write data.
- DatenRaus  out  32  read data, valid in the DatenBereit cycle.
- DatenBereit  out  1  one-cycle read-done pulse.
- DatenGeschrieben  out  1  one-cycle write-done pulse.
- Led  out  LEDBREITE  LED register contents.
- Unterbrechung  out  1  Treffer AND Freigabe.

Behaviour:
- Reset (async, Reset=0):
  - state LEERLAUF; DatenRaus=0; DatenBereit=0; DatenGeschrieben=0.
  - Led=0; Zaehler=0; Vergleich=32'hFFFFFFFF; Treffer=0; Freigabe=0; Unterbrechung=0.
- Register map, by Adresse[2:0]:
  - 0 LED: RW, write takes DatenRein[LEDBREITE-1:0]; read is zero-extended.
  - 1 Zaehler: RW, increments by 1 every cycle, wraps FFFFFFFF->0; a write loads DatenRein with no increment that cycle.
  - 2 Vergleich: RW, 32-bit.
  - 3 Status: bit0 Treffer (read; writing 1 clears, writing 0 no effect); bit1 Freigabe (RW); other bits read 0.
  - 4..7: read 0, writes ignored, still acknowledged.
- Treffer: set on any edge where the registered Zaehler equals Vergleich. If a set and a W1C clear occur on the same edge, the set wins.
- A request is active when (LesenAn|SchreibenAn) & Adresse[31]. If both LesenAn and SchreibenAn are high, the request is a write.
- State machine:
  - LEERLAUF: active request -> latch Adresse[2:0], DatenRein and read/write kind. Go to WARTEN with Warte=LATENZ, or go directly to FERTIG if LATENZ=0.
  - WARTEN: Warte decrements each cycle. If the request drops (both requests 0, or Adresse[31]=0), abort to LEERLAUF: no write, no pulse. At Warte==1, go to FERTIG.
  - FERTIG (one cycle):
    - Entering it, the write is committed, or DatenRaus is loaded with the selected register's value as of that edge.
    - DatenBereit or DatenGeschrieben is 1 for exactly this cycle.
    - Next state is SPERRE.
  - SPERRE: wait until LesenAn=0 and SchreibenAn=0, then go to LEERLAUF. A held request is never served twice.
- DatenRaus holds its last value outside FERTIG.
- Latency from request visible at an edge to the done pulse = LATENZ+1 cycles.
- Requests with Adresse[31]=0 are ignored completely: no state change, no pulse.
- Reset asserted mid-transaction: immediate return to the reset values; a pending write is lost.

Test Plan:
- Reset, LATENZ=1 -> write LED: Adresse=32'h80000000, DatenRein=32'h000000A5 -> DatenGeschrieben pulses exactly 2 cycles after the request, one cycle wide; Led=8'hA5. Read of the same address -> DatenRaus=32'h000000A5 with DatenBereit.
- Write Zaehler=32'hFFFFFFFE -> two cycles after commit, reads show a wrap to 0. Subsequent reads increase by the read spacing.
- Vergleich=32'h00000010, Freigabe=1, Zaehler=0 -> Treffer and Unterbrechung rise after Zaehler reaches 0x10. Write Status=32'h3 -> Treffer cleared, Freigabe stays 1.
- LesenAn and SchreibenAn both high to LED with 8'h3C -> treated as a write: only DatenGeschrieben pulses, Led=8'h3C. Request held high for 5 extra cycles -> no second pulse.
- Request dropped during WARTEN (LATENZ=3, drop after 1 cycle) -> no pulse, register unchanged. Request with Adresse[31]=0 -> no response at all.
- Reset asserted while in WARTEN on a write of 8'hFF -> all outputs return to reset values; Led=0 after reset is released.
